fifo_rd_pack: RTL and testbench
===============================

FIFO_RD_PACK -- requirements
Module: fifo_rd_pack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO read-data byte width.
REQ-002 SHALL have parameter LANES, default 4, bytes packed per output word.
REQ-003 SHALL have parameter TIMEOUT, default 16, idle cycles before a partial word is emitted.
REQ-004 SHALL have port rclk, input, 1, sole clock (FIFO read domain).
REQ-005 SHALL have port rrst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rempty, input, 1, FIFO empty flag.
REQ-007 SHALL have port rdata, input, DATA_WIDTH, FIFO head data, first-word fall-through (valid whenever rempty=0).
REQ-008 SHALL have port rinc, output, 1, FIFO pop strobe.
REQ-009 SHALL have port flush, input, 1, request immediate emission of any partial word.
REQ-010 SHALL have port out_data, output, DATA_WIDTH*LANES, packed word.
REQ-011 SHALL have port out_be, output, LANES, byte-enable per lane.
REQ-012 SHALL have port out_valid, output, 1, word valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-014 A pop SHALL occur in a cycle iff rinc=1; rinc SHALL never be 1 while rempty=1.
REQ-015 Popped bytes SHALL fill lanes little-endian: first byte in bits [DATA_WIDTH-1:0], lane count cnt 0..LANES.
REQ-016 FSM states SHALL be IDLE (cnt=0), ACCUM (0<cnt<LANES, collecting), PEND (word ready, output register busy).
REQ-017 rinc SHALL be 1 iff rempty=0 and state is IDLE or ACCUM, except rinc=0 when cnt=LANES-1 and the output register is busy (out_valid=1, out_ready=0).
REQ-018 Output register SHALL be free in a cycle when out_valid=0 or out_ready=1.
REQ-019 On the pop filling lane LANES-1 with output free, the word SHALL load into the output register at that clock edge, out_be all ones, cnt to 0, state to IDLE; sustained throughput SHALL be one byte per cycle.
REQ-020 flush=1 with cnt>0 (including a byte popped that cycle) SHALL emit a partial word: filled lanes carry data, unfilled lanes zero, out_be set only for filled lanes.
REQ-021 flush=1 with cnt=0 and no pop SHALL be ignored; flush coinciding with a pop completing a full word SHALL yield one full word only.
REQ-022 A saturating idle counter SHALL reset on every pop or emission and count while cnt>0; on reaching TIMEOUT, a partial emission per REQ-020 SHALL occur.
REQ-023 If an emission (full, flush, timeout) arises while output busy, state SHALL go to PEND with rinc=0; accumulator SHALL load on the first free cycle, then IDLE.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_be SHALL hold stable; out_valid SHALL drop the cycle after acceptance unless a new word loads.
REQ-025 No byte SHALL be dropped, duplicated or reordered.

Reset
REQ-026 When rrst=1 at a clock edge: out_valid=0, out_data=0, out_be=0, cnt=0, idle counter 0, state IDLE.
REQ-027 rinc SHALL be 0 in any cycle with rrst=1; reset mid-word SHALL discard accumulated bytes.

Structure
REQ-028 DATA_WIDTH, LANES, TIMEOUT defaults and the FSM state enum SHALL live in shared package fifo_pkg.
REQ-029 The idle counter SHALL be a sub-module fifo_idle_timer (inputs clear, enable; output expired).
REQ-030 All state SHALL be clocked on rclk only.

Verification
REQ-031 Stream bytes 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> one word 0x44332211, out_be=4'hF, rinc high 4 consecutive cycles.
REQ-032 Pop 0xAA,0xBB, then flush=1 -> word 0x0000BBAA, out_be=4'h3.
REQ-033 Pop 0x5A then rempty=1 for 16 cycles -> word 0x0000005A, out_be=4'h1 emitted on idle count 16.
REQ-034 out_ready=0 with first word held, stream 8 bytes -> rinc stalls at cnt=3, first word stable; release -> second word follows, no byte lost.
REQ-035 Pop 3 bytes, rrst=1 one cycle, then stream 0x01..0x04 -> only 0x04030201 emitted.
REQ-036 flush=1 with cnt=0 and rempty=1 -> out_valid stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and FSM state encoding for the FIFO read-side byte packer.
package fifo_pkg;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LANES      = 4;
  localparam int unsigned DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    PEND
  } state_t;
endpackage

// File: rtl/fifo_idle_timer.sv
// Saturating idle counter; expired flags the TIMEOUT-th consecutive idle cycle.
module fifo_idle_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable && r_count != TW'(TIMEOUT - 1)) begin
      r_count <= r_count + TW'(1);
    end
  end

  // Asserted during the idle cycle whose edge completes TIMEOUT idle cycles
  assign expired = enable && (r_count == TW'(TIMEOUT - 1));
endmodule

// File: rtl/fifo_rd_pack.sv
// Pops bytes from a FWFT FIFO and packs them little-endian into LANES-wide words
// with byte enables; partial words leave on flush or idle timeout.
module fifo_rd_pack
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                        rclk,
  input  logic                        rrst,
  input  logic                        rempty,
  input  logic [DATA_WIDTH-1:0]       rdata,
  output logic                        rinc,
  input  logic                        flush,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]            out_be,
  output logic                        out_valid,
  input  logic                        out_ready
);
  localparam int unsigned CW = $clog2(LANES + 1);
  localparam int unsigned WW = DATA_WIDTH * LANES;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_pop, w_cnt_nxt;
  logic [WW-1:0] r_acc, w_acc_pop, w_acc_nxt;
  logic [LANES-1:0] w_be_pop;
  logic w_free, w_emit, w_load, w_expired, w_timer_clr, w_timer_en;

  assign w_free = !out_valid || out_ready;

  // Holding off the last lane while busy keeps full words from ever needing PEND
  always_comb begin
    rinc = 1'b0;
    if (!rrst && !rempty && r_state != PEND) begin
      rinc = !(r_cnt == CW'(LANES - 1) && !w_free);
    end
  end

  assign w_cnt_pop = r_cnt + CW'(rinc);

  always_comb begin
    w_acc_pop = r_acc;
    w_be_pop  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (rinc && r_cnt == CW'(l)) begin
        w_acc_pop[l*DATA_WIDTH +: DATA_WIDTH] = rdata;
      end
      w_be_pop[l] = (CW'(l) < w_cnt_pop);
    end
  end

  always_comb begin
    w_emit      = 1'b0;
    w_load      = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    if (r_state == PEND) begin
      if (w_free) begin
        w_load      = 1'b1;
        w_cnt_nxt   = '0;
        w_acc_nxt   = '0;
        w_state_nxt = IDLE;
      end
    end else begin
      w_emit = (w_cnt_pop == CW'(LANES)) ||
               (w_cnt_pop != '0 && (flush || w_expired));
      if (w_emit && w_free) begin
        w_load      = 1'b1;
        w_cnt_nxt   = '0;
        w_acc_nxt   = '0;
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt = w_cnt_pop;
        w_acc_nxt = w_acc_pop;
        if (w_emit) begin
          w_state_nxt = PEND;
        end else begin
          w_state_nxt = (w_cnt_pop == '0) ? IDLE : ACCUM;
        end
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_be    <= '0;
    end else if (w_load) begin
      out_valid <= 1'b1;
      out_data  <= w_acc_pop;
      out_be    <= w_be_pop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign w_timer_clr = rinc || w_emit || w_load;
  assign w_timer_en  = (r_cnt != '0);

  fifo_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk    (rclk),
    .rst    (rrst),
    .clear  (w_timer_clr),
    .enable (w_timer_en),
    .expired(w_expired)
  );
endmodule

// File: tb/tb_fifo_rd_pack.sv
// Self-checking bench for fifo_rd_pack: directed vector table, hand sequences
// for stall and reset, and a randomized byte stream checked by a scoreboard.
module tb_fifo_rd_pack;
  logic        rclk;
  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_valid;
  logic        out_ready;

  fifo_rd_pack #(
    .DATA_WIDTH(8),
    .LANES     (4),
    .TIMEOUT   (16)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .flush    (flush),
    .out_data (out_data),
    .out_be   (out_be),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    int          n;
    logic [31:0] bytes;
    int          mode;   // 0 stream, 1 flush after, 2 flush with last pop, 3 timeout
    int          nw;
    logic [31:0] exp_d;
    logic [3:0]  exp_be;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_pop = 0;
  int n_pops   = 0;
  int n_viol   = 0;
  int n_unstable = 0;
  int use_src  = 0;
  int gap_pct  = 0;
  logic        was_held = 1'b0;
  logic [31:0] held_d;
  logic [3:0]  held_be;

  logic [7:0]  src[$];
  logic [7:0]  popped[$];
  logic [31:0] got_d[$];
  logic [3:0]  got_be[$];
  int          got_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: a word carries the next popcount(be) popped bytes, low lanes first
  task automatic check_word(input logic [31:0] d, input logic [3:0] be);
    int k;
    logic [31:0] exp_d;
    logic [3:0]  exp_be;
    logic        under;
    k = $countones(be);
    exp_be = 4'((1 << k) - 1);
    exp_d = '0;
    under = 1'b0;
    for (int l = 0; l < k; l++) begin
      if (popped.size() == 0) under = 1'b1;
      else exp_d[8*l +: 8] = popped.pop_front();
    end
    chk("word_nonempty", 64'(be != 4'h0), 64'd1);
    chk("word_bytes", 64'({1'b0, be, d}), 64'({under, exp_be, exp_d}));
  endtask

  task automatic tick();
    logic pop;
    logic acc;
    if (use_src != 0) begin
      rempty = (src.size() == 0) || ($urandom_range(99) < gap_pct);
      rdata  = (src.size() != 0) ? src[0] : 8'($urandom);
    end
    #1;
    pop = (rinc === 1'b1);
    if (pop && rempty) n_viol++;
    if (was_held && !(out_valid === 1'b1 && out_data === held_d && out_be === held_be))
      n_unstable++;
    acc = (out_valid === 1'b1) && out_ready;
    if (acc) begin
      got_d.push_back(out_data);
      got_be.push_back(out_be);
      got_cyc.push_back(cyc);
      check_word(out_data, out_be);
    end
    was_held = (out_valid === 1'b1) && !out_ready;
    held_d   = out_data;
    held_be  = out_be;
    if (pop) begin
      popped.push_back(rdata);
      last_pop = cyc;
      n_pops++;
      if (use_src != 0) void'(src.pop_front());
    end
    @(posedge rclk);
    if (rrst) begin
      popped.delete();
      was_held = 1'b0;
    end
    @(negedge rclk);
    cyc++;
  endtask

  task automatic do_reset();
    use_src = 0;
    src.delete();
    rrst = 1'b1; rempty = 1'b0; rdata = 8'hFF; flush = 1'b0; out_ready = 1'b1;
    n_pops = 0;
    tick();
    chk("rst_no_pop", 64'(n_pops), 64'd0);
    rrst = 1'b0; rempty = 1'b1;
    chk("rst_outputs", 64'({out_valid, out_be, out_data}), 64'd0);
    got_d.delete(); got_be.delete(); got_cyc.delete();
    n_pops = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    do_reset();
    for (int i = 0; i < v.n; i++) begin
      rempty = 1'b0;
      rdata  = v.bytes[8*i +: 8];
      flush  = (v.mode == 2 && i == v.n - 1);
      tick();
    end
    rempty = 1'b1;
    flush  = (v.mode == 1);
    tick();
    flush = 1'b0;
    repeat (24) tick();
    chk($sformatf("v%0d_pops", idx), 64'(n_pops), 64'(v.n));
    chk($sformatf("v%0d_nwords", idx), 64'(got_d.size()), 64'(v.nw));
    if (v.nw > 0 && got_d.size() > 0) begin
      chk($sformatf("v%0d_data", idx), 64'(got_d[0]), 64'(v.exp_d));
      chk($sformatf("v%0d_be", idx), 64'(got_be[0]), 64'(v.exp_be));
      chk($sformatf("v%0d_latency", idx), 64'(got_cyc[0] - last_pop), 64'(v.lat));
    end
  endtask

  initial begin
    vecs[0] = '{4, 32'h44332211, 0, 1, 32'h44332211, 4'hF, 1};
    vecs[1] = '{2, 32'h0000BBAA, 1, 1, 32'h0000BBAA, 4'h3, 2};
    vecs[2] = '{1, 32'h0000005A, 3, 1, 32'h0000005A, 4'h1, 17};
    vecs[3] = '{3, 32'h00030201, 2, 1, 32'h00030201, 4'h7, 1};
    vecs[4] = '{4, 32'hDDCCBBAA, 2, 1, 32'hDDCCBBAA, 4'hF, 1};
    vecs[5] = '{1, 32'h00000077, 2, 1, 32'h00000077, 4'h1, 1};
    vecs[6] = '{3, 32'h00C3B2A1, 3, 1, 32'h00C3B2A1, 4'h7, 17};
    vecs[7] = '{0, 32'h00000000, 1, 0, 32'h00000000, 4'h0, 0};

    rrst = 1'b1; rempty = 1'b1; rdata = '0; flush = 1'b0; out_ready = 1'b1;
    @(negedge rclk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Back-pressure: first word held while the accumulator fills to LANES-1
    do_reset();
    use_src = 1; gap_pct = 0; out_ready = 1'b0;
    for (int b = 1; b <= 8; b++) src.push_back(8'(b));
    repeat (20) tick();
    chk("stall_pops", 64'(n_pops), 64'd7);
    chk("stall_rinc", 64'(rinc), 64'd0);
    chk("stall_word", 64'({out_valid, out_be, out_data}), 64'({1'b1, 4'hF, 32'h04030201}));
    chk("stall_nwords", 64'(got_d.size()), 64'd0);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("release_nwords", 64'(got_d.size()), 64'd2);
    if (got_d.size() == 2) begin
      chk("release_w0", 64'(got_d[0]), 64'h04030201);
      chk("release_w1", 64'(got_d[1]), 64'h08070605);
    end
    chk("release_pops", 64'(n_pops), 64'd8);
    chk("stall_stable", 64'(n_unstable), 64'd0);

    // Reset mid-word discards accumulated bytes
    do_reset();
    use_src = 1; gap_pct = 0;
    src.push_back(8'hE1); src.push_back(8'hE2); src.push_back(8'hE3);
    repeat (3) tick();
    for (int b = 1; b <= 4; b++) src.push_back(8'(b));
    rrst = 1'b1;
    tick();
    chk("midrst_no_pop", 64'(n_pops), 64'd3);
    rrst = 1'b0;
    repeat (24) tick();
    chk("midrst_nwords", 64'(got_d.size()), 64'd1);
    if (got_d.size() > 0) begin
      chk("midrst_word", 64'(got_d[0]), 64'h04030201);
      chk("midrst_be", 64'(got_be[0]), 64'hF);
    end

    // Randomized stream: gaps, back-pressure and sporadic flushes
    do_reset();
    use_src = 1; gap_pct = 30;
    for (int b = 0; b < 300; b++) src.push_back(8'($urandom));
    for (int c = 0; c < 4000 && src.size() > 0; c++) begin
      out_ready = ($urandom_range(99) < 70);
      flush     = ($urandom_range(99) < 5);
      tick();
    end
    chk("rand_src_drained", 64'(src.size()), 64'd0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (30) tick();
    chk("rand_pops", 64'(n_pops), 64'd300);
    chk("rand_all_emitted", 64'(popped.size()), 64'd0);
    chk("rinc_while_empty", 64'(n_viol), 64'd0);
    chk("held_stable", 64'(n_unstable), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
